uart_rx: RTL and testbench

// - Receive path of the memory-mapped UART: deserialises 8N1 frames on uart_rx_i into an RX FIFO; the CPU drains it via loads.
// - Sits beside the UART TX on the IO bus and shares its select (mem_addr_i[IO_MEM_MAP_BIT] & mem_addr_i[UART_MEM_MAP_BIT]).
// - Word offset mem_addr_i[2]: 0 = RX_DATA, 1 = RX_STATUS.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// CPU load-port bundle shared by the UART receive block and its bus master.
// mem_rstrb_i is a one-cycle strobe per load and is never stalled. mem_rdata_o is combinational from the address and the current state.
// A load takes effect, by popping data or clearing flags, on the clock edge that ends the strobe cycle.
interface uart_rx_if;
  logic [31:0] mem_addr_i;
  logic        mem_rstrb_i;
  logic [31:0] mem_rdata_o;

  modport master (
    output mem_addr_i,
    output mem_rstrb_i,
    input  mem_rdata_o
  );

  modport slave (
    input  mem_addr_i,
    input  mem_rstrb_i,
    output mem_rdata_o
  );
endinterface

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding an RX FIFO that the CPU drains by loads.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
`ifndef IO_MEM_MAP_BIT
`define IO_MEM_MAP_BIT 22
`endif
`ifndef UART_MEM_MAP_BIT
`define UART_MEM_MAP_BIT 4
`endif

module uart_rx #(
  parameter int IO_MEM_MAP_BIT   = `IO_MEM_MAP_BIT,
  parameter int UART_MEM_MAP_BIT = `UART_MEM_MAP_BIT,
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_i,
  uart_rx_if.slave   bus,
  output logic       rx_irq_o,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_PARITY    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            push, fe_set, pe_set;

  logic            sync1_q, sync2_q;
  logic            line;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]  count_q;
  logic            empty, full;
  logic            do_push, do_pop, overrun_set;

  logic            overrun_q, framing_err_q, parity_err_q;
  logic            sel, data_rd, status_rd;
  logic [7:0]      head_byte;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // The START state decides at mid-bit. Every later sample falls a whole bit period after the one before it, so each sample lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!line) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (line) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            par_bad_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if (line != ^shift_q) begin
            pe_set    = 1'b1;
            par_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (line) begin
            push    = !par_bad_q;
            state_d = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  assign sel       = bus.mem_addr_i[IO_MEM_MAP_BIT] & bus.mem_addr_i[UART_MEM_MAP_BIT];
  assign data_rd   = sel & bus.mem_rstrb_i & !bus.mem_addr_i[2];
  assign status_rd = sel & bus.mem_rstrb_i &  bus.mem_addr_i[2];

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);
  assign do_pop      = data_rd & !empty;
  // A full FIFO still accepts a byte when a pop on the same edge frees a slot.
  assign do_push     = push & (!full | do_pop);
  assign overrun_set = push & full & !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[tail_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A status read clears the sticky flags, but an error raised on that same edge still sets its flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      rx_irq_o      <= 1'b0;
    end else begin
      overrun_q     <= overrun_set | (overrun_q     & !status_rd);
      framing_err_q <= fe_set      | (framing_err_q & !status_rd);
      parity_err_q  <= pe_set      | (parity_err_q  & !status_rd);
      rx_irq_o      <= !empty;
    end
  end

  assign head_byte = empty ? 8'h00 : fifo_mem[head_q];

  always_comb begin
    bus.mem_rdata_o = 32'h0;
    if (sel) begin
      if (bus.mem_addr_i[2])
        bus.mem_rdata_o = {27'b0, parity_err_q, framing_err_q, overrun_q, full, !empty};
      else
        bus.mem_rdata_o = {23'b0, !empty, head_byte};
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames at 10 clk/bit, checked against a byte-level FIFO/flag model.
module tb_uart_rx;
  localparam int CPB      = 10;
  localparam int IO_BIT   = 22;
  localparam int UART_BIT = 4;
  localparam int DEPTH    = 8;
  localparam logic [31:0] SEL_ADDR = (32'h1 << IO_BIT) | (32'h1 << UART_BIT);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line = 1'b1;
  logic       rx_irq;
  logic [2:0] dbg_state;
  uart_rx_if  bus();

  // Clock/reset block.
  always #5 clk = ~clk;

  uart_rx #(
    .IO_MEM_MAP_BIT  (IO_BIT),
    .UART_MEM_MAP_BIT(UART_BIT),
    .CLK_FREQ_HZ     (10_000_000),
    .BAUD_RATE       (1_000_000),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx_i(line),
    .bus      (bus),
    .rx_irq_o (rx_irq),
    .dbg_state(dbg_state)
  );

  // Scoreboard: expected FIFO contents and sticky flags.
  logic [7:0] exp_q[$];
  logic       ov_m, fe_m, pe_m;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: start bit, 8 data bits LSB first, optional parity, then stop. The line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    line = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_clks(CPB);
    end
`ifdef UART_RX_PARITY_EN
    line = (^b) ^ !par_ok;
    wait_clks(CPB);
`endif
    line = stop;
    wait_clks(CPB);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_ok);
`ifdef UART_RX_PARITY_EN
    if (!par_ok) pe_m = 1'b1;
`else
    par_ok = 1'b1;
`endif
    if (!stop) fe_m = 1'b1;
    else if (par_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ov_m = 1'b1;
    end
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
    bus.mem_addr_i  = addr;
    bus.mem_rstrb_i = 1'b1;
    #1 data = bus.mem_rdata_o;
    @(negedge clk);
    bus.mem_rstrb_i = 1'b0;
    bus.mem_addr_i  = 32'h0;
  endtask

  task automatic read_check(input string tag, input logic off);
    logic [31:0] exp, got;
    if (off)
      exp = {27'b0, pe_m, fe_m, ov_m, exp_q.size() == DEPTH, exp_q.size() != 0};
    else
      exp = (exp_q.size() != 0) ? {23'b0, 1'b1, exp_q[0]} : 32'h0;
    cpu_read(SEL_ADDR | (32'(off) << 2), got);
    check(tag, got, exp);
    if (off) begin
      ov_m = 1'b0;
      fe_m = 1'b0;
      pe_m = 1'b0;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_irq(input string tag);
    wait_clks(2);
    check(tag, {31'b0, rx_irq}, {31'b0, exp_q.size() != 0});
  endtask

  initial begin
    logic [31:0] got;
    logic [7:0]  b;
    int          r;
    logic        p;
    ov_m = 1'b0; fe_m = 1'b0; pe_m = 1'b0;
    bus.mem_addr_i  = 32'h0;
    bus.mem_rstrb_i = 1'b0;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(3);

    check("rst_irq", {31'b0, rx_irq}, 32'h0);
    check("rst_state", {29'b0, dbg_state}, 32'h0);
    read_check("rst_status", 1'b1);
    read_check("rst_data", 1'b0);

    send_frame(8'hA5, 1'b1, 1'b1); model_frame(8'hA5, 1'b1, 1'b1);
    check_irq("a5_irq_hi");
    read_check("a5_data", 1'b0);
    check_irq("a5_irq_lo");
    read_check("a5_status", 1'b1);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h41 + 8'(i), 1'b1, 1'b1);
      model_frame(8'h41 + 8'(i), 1'b1, 1'b1);
    end
    for (int i = 0; i < 4; i++) read_check("abc_data", 1'b0);

    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      model_frame(8'(i), 1'b1, 1'b1);
    end
    cpu_read(32'h0000_0004, got);
    check("unsel_status", got, 32'h0);
    cpu_read(32'(1) << IO_BIT, got);
    check("unsel_data", got, 32'h0);
    read_check("ovr_status", 1'b1);
    read_check("ovr_status2", 1'b1);
    for (int i = 0; i < 9; i++) read_check("ovr_data", 1'b0);

    send_frame(8'h55, 1'b0, 1'b1); model_frame(8'h55, 1'b0, 1'b1);
    wait_clks(30);
    line = 1'b1;
    wait_clks(5);
    check("fe_state", {29'b0, dbg_state}, 32'h0);
    read_check("fe_status", 1'b1);
    send_frame(8'h33, 1'b1, 1'b1); model_frame(8'h33, 1'b1, 1'b1);
    read_check("fe_next_data", 1'b0);

    line = 1'b0;
    wait_clks(3);
    line = 1'b1;
    wait_clks(20);
    check("glitch_state", {29'b0, dbg_state}, 32'h0);
    read_check("glitch_status", 1'b1);
    read_check("glitch_data", 1'b0);

    send_frame(8'h77, 1'b1, 1'b1); model_frame(8'h77, 1'b1, 1'b1);
    line = 1'b0;
    wait_clks(25);
    rst = 1'b0;
    wait_clks(3);
    line = 1'b1;
    rst  = 1'b1;
    exp_q.delete();
    ov_m = 1'b0; fe_m = 1'b0; pe_m = 1'b0;
    check_irq("mid_rst_irq");
    check("mid_rst_state", {29'b0, dbg_state}, 32'h0);
    read_check("mid_rst_status", 1'b1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0); model_frame(8'h03, 1'b1, 1'b0);
    read_check("par_bad_status", 1'b1);
    read_check("par_bad_data", 1'b0);
    send_frame(8'h03, 1'b1, 1'b1); model_frame(8'h03, 1'b1, 1'b1);
    read_check("par_ok_data", 1'b0);
`endif

    for (int it = 0; it < 30; it++) begin
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      p = ($urandom_range(0, 5) != 0);
      if (r == 0) begin
        send_frame(b, 1'b0, p); model_frame(b, 1'b0, p);
        wait_clks($urandom_range(1, 20));
        line = 1'b1;
        wait_clks(4);
      end else begin
        send_frame(b, 1'b1, p); model_frame(b, 1'b1, p);
        wait_clks($urandom_range(0, 3));
      end
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) read_check("rnd_read", 1'($urandom_range(0, 1)));
      check_irq("rnd_irq");
    end
    read_check("drain_status", 1'b1);
    for (int i = 0; i <= DEPTH; i++) read_check("drain_data", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
